// File: rtl/systolic_mac_array_pkg.sv
// Shared types and size derivations for the systolic MAC array
// and the operand registers that feed it.
package systolic_mac_array_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic int max_dim(input int bus_w, input int data_w);
      return bus_w / data_w;
   endfunction

   function automatic int cnt_w(input int md);
      return $clog2(3 * md - 2);
   endfunction

   function automatic int acc_w(input int data_w);
      return 2 * data_w;
   endfunction

endpackage

// File: rtl/systolic_mac_array_pe.sv
// One output-stationary MAC cell: accumulator, sticky overflow,
// east/south operand pass registers and a synchronous clear.
module systolic_pe
   import systolic_mac_array_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = acc_w(DATA_WIDTH)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clr_i,
   input  logic                         en_i,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   output logic        [DATA_WIDTH-1:0] a_o,
   output logic        [DATA_WIDTH-1:0] b_o,
   output logic        [ACC_WIDTH-1:0]  acc_o,
   output logic                         ovf_o
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    addend;
   logic signed [ACC_WIDTH-1:0]    sum;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic                           ovf_set;

   // Signed product, sign-extended, wrap-around add, overflow detect
   always_comb begin
      prod    = a_i * b_i;
      addend  = ACC_WIDTH'(prod);
      sum     = acc_q + addend;
      ovf_set = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
   end

   // Accumulate and forward operands while enabled; clear on run entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         ovf_o <= 1'b0;
         a_o   <= '0;
         b_o   <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
         ovf_o <= 1'b0;
         a_o   <= '0;
         b_o   <= '0;
      end else if (en_i) begin
         acc_q <= sum;
         a_o   <= a_i;
         b_o   <= b_i;
         if (ovf_set) ovf_o <= 1'b1;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary systolic MAC grid: run FSM, skew counter,
// PE grid and result/overflow read muxing.
module systolic_mac_array
   import systolic_mac_array_pkg::*;
#(
   parameter  int BUS_WIDTH  = 16,
   parameter  int DATA_WIDTH = 8,
   parameter  int ACC_WIDTH  = acc_w(DATA_WIDTH),
   localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int CNT_W      = cnt_w(MAX_DIM),
   localparam int ADDR_W     = $clog2(MAX_DIM)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [BUS_WIDTH-1:0]           a_buff_i,
   input  logic [BUS_WIDTH-1:0]           b_buff_i,
   output logic [CNT_W-1:0]               counter_o,
   output logic                           start_bit_o,
   output logic                           busy_o,
   output logic                           done_o,
   input  logic [ADDR_W-1:0]              res_addr_i,
   output logic [MAX_DIM*ACC_WIDTH-1:0]   res_data_o,
   output logic [MAX_DIM*MAX_DIM-1:0]     overflow_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(3 * MAX_DIM - 3);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clr;
   logic             run;

   logic [DATA_WIDTH-1:0] a_e [MAX_DIM][MAX_DIM+1];
   logic [DATA_WIDTH-1:0] b_s [MAX_DIM+1][MAX_DIM];
   logic [ACC_WIDTH-1:0]  acc [MAX_DIM][MAX_DIM];
   logic                  ovf [MAX_DIM][MAX_DIM];
   logic                  unused_pass;

   // State and skew counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and grid clear on run entry
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = RUN;
               clr     = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q == LAST) state_d = DONE;
            else cnt_d = cnt_q + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign run         = (state_q == RUN);
   assign busy_o      = run;
   assign start_bit_o = run;
   assign done_o      = (state_q == DONE);
   assign counter_o   = cnt_q;

   for (genvar i = 0; i < MAX_DIM; i++) begin : g_edge
      assign a_e[i][0] = a_buff_i[i*DATA_WIDTH +: DATA_WIDTH];
      assign b_s[0][i] = b_buff_i[i*DATA_WIDTH +: DATA_WIDTH];
   end

   for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
      for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
         systolic_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
         ) u_pe (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr),
            .en_i   (run),
            .a_i    (a_e[i][j]),
            .b_i    (b_s[i][j]),
            .a_o    (a_e[i][j+1]),
            .b_o    (b_s[i+1][j]),
            .acc_o  (acc[i][j]),
            .ovf_o  (ovf[i][j])
         );
         assign overflow_o[i*MAX_DIM+j] = ovf[i][j];
      end
   end

   // Operands leaving the east and south edges are dropped
   always_comb begin
      unused_pass = 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
         unused_pass = unused_pass ^ (^a_e[i][MAX_DIM])
                                   ^ (^b_s[MAX_DIM][i]);
      end
   end

   // Zero-latency read of result row res_addr_i
   always_comb begin
      res_data_o = '0;
      for (int j = 0; j < MAX_DIM; j++) begin
         res_data_o[j*ACC_WIDTH +: ACC_WIDTH] = acc[res_addr_i][j];
      end
   end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Randomised + directed bench for systolic_mac_array with a
// behavioural matrix-product model and per-cycle comparison.
module tb_systolic_mac_array;

   localparam int N    = 2;
   localparam int DW   = 8;
   localparam int AW   = 16;
   localparam int BW   = N * DW;
   localparam int CW   = $clog2(3 * N - 2);
   localparam int LAST = 3 * N - 3;

   logic          clk;
   logic          rst_ni;
   logic          start_i;
   logic [BW-1:0] a_buff;
   logic [BW-1:0] b_buff;
   logic [CW-1:0] counter;
   logic          start_bit;
   logic          busy;
   logic          done;
   logic [0:0]    res_addr;
   logic [N*AW-1:0] res_data;
   logic [N*N-1:0]  overflow;

   logic signed [DW-1:0] ma [N][N];
   logic signed [DW-1:0] mb [N][N];

   int since;
   int exp_c [N][N];
   logic [N*N-1:0] exp_ov;
   int obs_c [N][N];
   logic [N*N-1:0] obs_ov;

   int n_cmp;
   int n_bad;

   systolic_mac_array u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .a_buff_i    (a_buff),
      .b_buff_i    (b_buff),
      .counter_o   (counter),
      .start_bit_o (start_bit),
      .busy_o      (busy),
      .done_o      (done),
      .res_addr_i  (res_addr),
      .res_data_o  (res_data),
      .overflow_o  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Operand registers: skewed lanes for the current counter value
   always_comb begin
      a_buff = '0;
      b_buff = '0;
      if (start_bit) begin
         for (int r = 0; r < N; r++) begin
            automatic int k = int'(counter) - r;
            if (k >= 0 && k < N) begin
               a_buff[r*DW +: DW] = ma[r][k];
               b_buff[r*DW +: DW] = mb[k][r];
            end
         end
      end
   end

   // Reference: C = A*B with 16-bit wrap, overflow when a true partial sum leaves range
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         since <= -1;
      end else if (start_i && !(since >= 0 && since <= LAST)) begin
         since <= 0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               automatic int acc_m = 0;
               automatic bit ov = 1'b0;
               for (int k = 0; k < N; k++) begin
                  automatic int full = acc_m + int'(ma[i][k]) * int'(mb[k][j]);
                  automatic logic signed [AW-1:0] w = full[AW-1:0];
                  if (full > 32767 || full < -32768) ov = 1'b1;
                  acc_m = int'(w);
               end
               exp_c[i][j]    <= acc_m;
               exp_ov[i*N+j] <= ov;
            end
         end
      end else if (since >= 0 && since < LAST + 1) begin
         since <= since + 1;
      end
   end

   // Per-cycle comparison of control outputs and, when meaningful, results
   always @(negedge clk) begin
      automatic bit eb = (since >= 0 && since <= LAST);
      automatic bit ed = (since > LAST);
      chk("busy", busy, eb);
      chk("start_bit", start_bit, eb);
      chk("done", done, ed);
      chk("counter", counter, eb ? since : 0);
      if (ed || since <= 0) begin
         for (int r = 0; r < N; r++) begin
            res_addr = r[0:0];
            #1;
            for (int j = 0; j < N; j++) begin
               automatic logic signed [AW-1:0] v = res_data[j*AW +: AW];
               obs_c[r][j] = int'(v);
               chk("res", obs_c[r][j], ed ? exp_c[r][j] : 0);
            end
         end
         obs_ov = overflow;
         chk("ovf", overflow, ed ? exp_ov : '0);
      end
   end

   task automatic set_ab(input int a[4], input int b[4]);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            ma[i][j] = DW'(a[i*N+j]);
            mb[i][j] = DW'(b[i*N+j]);
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   // Count falling edges until done, optionally poking start mid-run
   task automatic wait_done(input int poke_at, output int lat);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         start_i = (n == poke_at);
         if (done && lat == 0) lat = n;
         if (lat != 0) break;
      end
      start_i = 1'b0;
      if (lat == 0) chk("done_timeout", 0, 1);
      #3;
   endtask

   task automatic chk_c(input string name, input int c[4], input int ov);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            chk(name, obs_c[i][j], c[i*N+j]);
         end
      end
      chk({name, "_ovf"}, obs_ov, ov);
   endtask

   initial begin
      automatic int lat;
      n_cmp    = 0;
      n_bad    = 0;
      rst_ni   = 1'b0;
      start_i  = 1'b0;
      res_addr = '0;
      set_ab('{0, 0, 0, 0}, '{0, 0, 0, 0});
      repeat (3) @(negedge clk);
      #3 rst_ni = 1'b1;

      set_ab('{1, 2, 3, 4}, '{5, 6, 7, 8});
      pulse_start();
      wait_done(0, lat);
      chk("latency", lat, 5);
      chk_c("unsigned", '{19, 22, 43, 50}, 0);

      set_ab('{-1, 2, 3, -4}, '{5, -6, 7, 8});
      pulse_start();
      wait_done(0, lat);
      chk_c("signed", '{9, 22, -13, -50}, 0);

      set_ab('{-128, -128, 0, 0}, '{-128, 0, -128, 0});
      pulse_start();
      wait_done(0, lat);
      chk_c("wrap", '{-32768, 0, 0, 0}, 1);

      set_ab('{1, 1, 1, 1}, '{1, 1, 1, 1});
      pulse_start();
      wait_done(0, lat);
      chk_c("ovf_clear", '{2, 2, 2, 2}, 0);

      set_ab('{7, 0, 0, 0}, '{9, 0, 0, 0});
      pulse_start();
      wait_done(0, lat);
      chk_c("one_by_one", '{63, 0, 0, 0}, 0);

      // Reset in the middle of a run
      set_ab('{1, 2, 3, 4}, '{5, 6, 7, 8});
      pulse_start();
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (counter == CW'(2)) break;
      end
      #3 rst_ni = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", counter, 0);
      chk("rst_sbit", start_bit, 0);
      chk("rst_res", res_data, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      #3 rst_ni = 1'b1;
      set_ab('{2, 0, 0, 3}, '{4, 1, 1, 5});
      pulse_start();
      wait_done(0, lat);
      chk_c("after_rst", '{8, 2, 3, 15}, 0);

      // start ignored while running
      set_ab('{1, 2, 3, 4}, '{5, 6, 7, 8});
      pulse_start();
      wait_done(2, lat);
      chk("run_poke_lat", lat, 5);
      chk_c("run_poke", '{19, 22, 43, 50}, 0);

      // start in DONE restarts with cleared accumulators
      set_ab('{-1, 2, 3, -4}, '{5, -6, 7, 8});
      pulse_start();
      wait_done(0, lat);
      chk("restart_lat", lat, 5);
      chk_c("restart", '{9, 22, -13, -50}, 0);

      // Random operands, extremes mixed in, random active dimensions
      for (int t = 0; t < 40; t++) begin
         automatic int ka = $urandom_range(1, N);
         automatic int kb = $urandom_range(1, N);
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               automatic int sel = $urandom_range(0, 5);
               automatic int va = sel == 0 ? -128 : sel == 1 ? 127 : int'($urandom_range(0, 255)) - 128;
               automatic int vb = sel == 0 ? -128 : sel == 2 ? -128 : int'($urandom_range(0, 255)) - 128;
               ma[i][j] = (j < ka) ? DW'(va) : '0;
               mb[i][j] = (j < kb) ? DW'(vb) : '0;
            end
         end
         pulse_start();
         wait_done(($urandom_range(0, 3) == 0) ? 3 : 0, lat);
         chk("rand_lat", lat, 5);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
